// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port among NUM_REQ requesters
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_grant,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_almostfull,
    input  logic                          i_fifo_overflow,
    output logic                          o_wr_en,
    output logic [DATA_WIDTH-1:0]         o_data_in,
    output logic [IW-1:0]                 o_owner,
    output logic                          o_busy,
    output logic                          o_ovf_err
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                r_state, w_state_n;
    logic [IW-1:0]         r_rr_ptr, w_rr_n, r_owner, w_owner_n, w_winner, w_cand, w_sel;
    logic [3:0]            r_beat_cnt, w_beat_n;
    logic                  w_found, w_space, w_gnt;
    logic                  r_wr_en, r_ovf_err;
    logic [DATA_WIDTH-1:0] r_data_in;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] p);
        return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // the registered write in flight already claims the last free slot
    assign w_space   = !i_fifo_full && !(i_fifo_almostfull && r_wr_en);
    assign o_grant   = w_gnt ? NUM_REQ'(1) << w_sel : '0;
    assign o_wr_en   = r_wr_en;
    assign o_data_in = r_data_in;
    assign o_owner   = r_owner;
    assign o_busy    = (r_state == BURST);
    assign o_ovf_err = r_ovf_err;

    // first requesting index scanning upward from rr_ptr with wrap
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // next-state, burst accounting and grant decision
    always_comb begin
        w_state_n = r_state;
        w_rr_n    = r_rr_ptr;
        w_beat_n  = r_beat_cnt;
        w_owner_n = r_owner;
        w_gnt     = 1'b0;
        w_sel     = r_owner;
        if (r_state == IDLE) begin
            w_sel = w_winner;
            if (w_space && w_found) begin
                w_gnt     = 1'b1;
                w_owner_n = w_winner;
                w_beat_n  = 4'd1;
                if (MAX_BURST > 1) w_state_n = BURST;
                else w_rr_n = next_idx(w_winner);
            end
        end else if (!i_req[r_owner]) begin
            w_state_n = IDLE;
            w_rr_n    = next_idx(r_owner);
        end else if (w_space) begin
            w_gnt    = 1'b1;
            w_beat_n = r_beat_cnt + 4'd1;
            if (w_beat_n == 4'(MAX_BURST)) begin
                w_state_n = IDLE;
                w_rr_n    = next_idx(r_owner);
            end
        end
        if (rst) w_gnt = 1'b0;
    end

    // state registers plus the one-cycle-latency FIFO write stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_owner    <= '0;
            r_wr_en    <= 1'b0;
            r_data_in  <= '0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_rr_ptr   <= w_rr_n;
            r_beat_cnt <= w_beat_n;
            r_owner    <= w_owner_n;
            r_wr_en    <= w_gnt;
            if (w_gnt) r_data_in <= i_req_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
            r_ovf_err  <= r_ovf_err | i_fifo_overflow;
        end
    end
endmodule
